// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Scancode set 2 prefix bytes, key word field positions, frame FSM state.
package ps2_pkg;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_EE = 8'hEE;
    localparam logic [7:0] B_FE = 8'hFE;

    localparam int KEY_TOG = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    // Bytes still to drop after E1 (rest of the Pause sequence).
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver.
// Emits one-cycle byte_valid_o or frame_err_o per frame.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk_sys,
    input  logic       RESET_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLIM = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    rx_state_e     state_q;
    logic [2:0]    bcnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          valid_q;
    logic          err_q;
    logic          clk_s;
    logic          dat_s;
    logic          fe;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Falling edge of the filtered clock, seen in the cycle it flips.
    assign fe = filt_q & ~clk_s & (fcnt_q == FLIM);

    // Two-flop synchronizers; idle PS/2 lines are high.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
        end
    end

    // Clock filter: level follows only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (clk_s == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FLIM) begin
            filt_q <= clk_s;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // Frame FSM with mid-frame timeout and registered strobes.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (fe) begin
                tmo_q <= '0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state_q <= ST_DATA;
                            bcnt_q  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg_q <= {dat_s, shreg_q[7:1]};
                        bcnt_q  <= bcnt_q + 1'b1;
                        if (bcnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (dat_s && (^{shreg_q, par_q})) begin
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (state_q != ST_IDLE) begin
                if (tmo_q == TLIM) begin
                    state_q <= ST_IDLE;
                    tmo_q   <= '0;
                    err_q   <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign byte_o       = shreg_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to toggle-format key event encoder.
// Interprets set 2 prefixes and owns the ps2_key register.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_err;
    logic [10:0] key_q;
    logic        ext_q;
    logic        brk_q;
    logic [2:0]  skip_q;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys      (clk_sys),
        .RESET_n      (RESET_n),
        .ps2_clk_i    (ps2_clk_in),
        .ps2_data_i   (ps2_data_in),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err),
        .busy_o       (busy)
    );

    // Prefix interpreter: E0/F0 flags, Pause skip, key event emission.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else if (rx_err) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else if (rx_valid) begin
            if (skip_q != 3'd0) begin
                skip_q <= skip_q - 1'b1;
            end else begin
                case (rx_byte)
                    B_E1: skip_q <= PAUSE_SKIP;
                    B_E0: ext_q  <= 1'b1;
                    B_F0: brk_q  <= 1'b1;
                    B_FA, B_AA, B_EE, B_FE, 8'h00, 8'hFF: begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                    default: begin
                        key_q[KEY_TOG] <= ~key_q[KEY_TOG];
                        key_q[KEY_PRS] <= ~brk_q;
                        key_q[KEY_EXT] <= ext_q;
                        key_q[7:0]     <= rx_byte;
                        ext_q          <= 1'b0;
                        brk_q          <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = rx_err;

endmodule
